// File: rtl/lpf_decimator.sv
// lpf_decimator: decimating output stage for the Tustin low-pass filter.
//
// Keeps one filter sample out of every `ratio` valid samples. Each kept
// sample is reduced from Q1.(IN_BITS-1) to Q1.(OUT_BITS-1) and offered on a
// ready/valid stream through a 2-entry first-word-fall-through buffer. A kept
// sample that finds the buffer full, with no pop in the same cycle, is
// dropped, and the sticky overflow flag is set.
//
// Optional feature (compile-time macro LPF_DECIM_ROUND_EN):
//   defined   - round half-up before reduction, saturating at positive max
//   undefined - truncate (toward -inf)
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   in             signed filter sample, IN_BITS
//   in_valid       one-cycle strobe per filter sample
//   ratio          unsigned decimation factor (0 behaves as 1)
//   out_data       signed decimated sample, OUT_BITS (head of buffer)
//   out_valid      buffer not empty
//   out_ready      consumer accepts out_data when high with out_valid
//   overflow       sticky: a selected sample was dropped
//   clear_overflow clears overflow (a simultaneous drop wins)
module lpf_decimator #(
  parameter int unsigned IN_BITS    = 32,
  parameter int unsigned OUT_BITS   = 16,
  parameter int unsigned RATIO_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_BITS-1:0]    in,
  input  logic                  in_valid,
  input  logic [RATIO_BITS-1:0] ratio,
  output logic [OUT_BITS-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow,
  input  logic                  clear_overflow
);

  localparam int unsigned SHIFT     = IN_BITS - OUT_BITS;
  localparam int unsigned CNT_BITS  = 2;

  // ---------------------------------------------------------------------
  // Phase counter and latched decimation ratio
  // ---------------------------------------------------------------------
  logic [RATIO_BITS-1:0] ratio_sat_c;
  logic [RATIO_BITS-1:0] ratio_reg;
  logic [RATIO_BITS-1:0] eff_ratio_c;
  logic [RATIO_BITS-1:0] phase;
  logic                  ratio_loaded;
  logic                  phase_wrap_c;
  logic                  select_c;

  assign ratio_sat_c  = (ratio == '0) ? RATIO_BITS'(1) : ratio;
  // Until the first post-reset load, the live ratio input stands in for
  // ratio_reg so a sample arriving on that very cycle sees a sane period.
  assign eff_ratio_c  = ratio_loaded ? ratio_reg : ratio_sat_c;
  assign phase_wrap_c = (phase == (eff_ratio_c - RATIO_BITS'(1)));
  assign select_c     = in_valid && (phase == '0);

  // Counter advances on in_valid only; ratio reloads at each period boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase        <= '0;
      ratio_reg    <= RATIO_BITS'(1);
      ratio_loaded <= 1'b0;
    end else begin
      ratio_loaded <= 1'b1;
      if (!ratio_loaded) begin
        ratio_reg <= ratio_sat_c;
      end
      if (in_valid) begin
        if (phase_wrap_c) begin
          phase     <= '0;
          ratio_reg <= ratio_sat_c;
        end else begin
          phase <= phase + RATIO_BITS'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Width reduction (combinational), then one register stage
  // ---------------------------------------------------------------------
  logic [OUT_BITS-1:0] top_c;
  logic [OUT_BITS-1:0] conv_c;
  logic                unused_low_c;

  assign top_c        = in[IN_BITS-1 -: OUT_BITS];
  assign unused_low_c = ^in[SHIFT-1:0];

`ifdef LPF_DECIM_ROUND_EN
  localparam logic [OUT_BITS-1:0] POS_MAX = {1'b0, {(OUT_BITS-1){1'b1}}};
  logic [OUT_BITS:0] rnd_sum_c;

  // Sign-extend by one bit so a carry out of the positive maximum shows up
  // as a sign disagreement; negative inputs only move toward zero.
  assign rnd_sum_c = {top_c[OUT_BITS-1], top_c} + (OUT_BITS+1)'(in[SHIFT-1]);
  assign conv_c    = (rnd_sum_c[OUT_BITS] != rnd_sum_c[OUT_BITS-1]) ?
                     POS_MAX : rnd_sum_c[OUT_BITS-1:0];
`else
  assign conv_c = top_c;
`endif

  logic [OUT_BITS-1:0] conv_data;
  logic                conv_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      conv_data  <= '0;
      conv_valid <= 1'b0;
    end else begin
      conv_valid <= select_c;
      if (select_c) begin
        conv_data <= conv_c;
      end
    end
  end

  // ---------------------------------------------------------------------
  // 2-entry FWFT buffer: head register drives out_data directly
  // ---------------------------------------------------------------------
  logic [OUT_BITS-1:0] head;
  logic [OUT_BITS-1:0] tail;
  logic [CNT_BITS-1:0] count;
  logic [OUT_BITS-1:0] head_next_c;
  logic [OUT_BITS-1:0] tail_next_c;
  logic [CNT_BITS-1:0] count_next_c;
  logic                pop_c;
  logic                full_c;
  logic                push_c;
  logic                drop_c;

  assign pop_c  = out_valid && out_ready;
  assign full_c = (count == CNT_BITS'(2));
  // A full buffer still takes a push when its head leaves the same cycle.
  assign push_c = conv_valid && (!full_c || pop_c);
  assign drop_c = conv_valid && full_c && !pop_c;

  // Next-state of the buffer for every push/pop combination.
  always_comb begin
    head_next_c  = head;
    tail_next_c  = tail;
    count_next_c = count;
    unique case ({push_c, pop_c})
      2'b10: begin
        if (count == '0) begin
          head_next_c = conv_data;
        end else begin
          tail_next_c = conv_data;
        end
        count_next_c = count + CNT_BITS'(1);
      end
      2'b01: begin
        head_next_c  = tail;
        count_next_c = count - CNT_BITS'(1);
      end
      2'b11: begin
        if (count == CNT_BITS'(1)) begin
          head_next_c = conv_data;
        end else begin
          head_next_c = tail;
          tail_next_c = conv_data;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      head      <= head_next_c;
      tail      <= tail_next_c;
      count     <= count_next_c;
      out_valid <= (count_next_c != '0);
    end
  end

  assign out_data = head;

  // Sticky drop flag; a drop in the clearing cycle keeps it set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else begin
      overflow <= drop_c || (overflow && !clear_overflow);
    end
  end

endmodule

// File: tb/tb_lpf_decimator.sv
module tb_lpf_decimator;

  localparam int unsigned IN_BITS    = 32;
  localparam int unsigned OUT_BITS   = 16;
  localparam int unsigned RATIO_BITS = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [IN_BITS-1:0]    in;
  logic                  in_valid;
  logic [RATIO_BITS-1:0] ratio;
  logic [OUT_BITS-1:0]   out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  overflow;
  logic                  clear_overflow;

  int checks = 0;
  int errors = 0;

  lpf_decimator #(
    .IN_BITS   (IN_BITS),
    .OUT_BITS  (OUT_BITS),
    .RATIO_BITS(RATIO_BITS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in            (in),
    .in_valid      (in_valid),
    .ratio         (ratio),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .overflow      (overflow),
    .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] din;
    logic [15:0] rat;
    logic [15:0] exp_trn;
    logic [15:0] exp_rnd;
  } conv_vec_t;

  localparam int NV = 8;
  conv_vec_t cv[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] r);
    rst            = 1'b1;
    in_valid       = 1'b0;
    clear_overflow = 1'b0;
    ratio          = r;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [15:0] exp_of(input int i);
`ifdef LPF_DECIM_ROUND_EN
    return cv[i].exp_rnd;
`else
    return cv[i].exp_trn;
`endif
  endfunction

  initial begin
    cv[0] = '{32'h1234_5678, 16'd0, 16'h1234, 16'h1234};
    cv[1] = '{32'h7FFF_8000, 16'd1, 16'h7FFF, 16'h7FFF};
    cv[2] = '{32'h1234_8000, 16'd0, 16'h1234, 16'h1235};
    cv[3] = '{32'h8000_0000, 16'd1, 16'h8000, 16'h8000};
    cv[4] = '{32'hFFFF_8000, 16'd0, 16'hFFFF, 16'h0000};
    cv[5] = '{32'hFFFF_7FFF, 16'd1, 16'hFFFF, 16'hFFFF};
    cv[6] = '{32'h0000_0000, 16'd0, 16'h0000, 16'h0000};
    cv[7] = '{32'h7FFF_FFFF, 16'd1, 16'h7FFF, 16'h7FFF};

    in        = '0;
    out_ready = 1'b1;

    // Reset state and conversion table, one sample per clock, ratio 0/1.
    do_reset(16'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", 32'(out_data), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < NV + 2; i++) begin
      if (i >= 2) begin
        chk($sformatf("conv[%0d] valid", i - 2), 32'(out_valid), 32'd1);
        chk($sformatf("conv[%0d] data", i - 2), 32'(out_data), 32'(exp_of(i - 2)));
      end
      if (i < NV) begin
        in_valid = 1'b1;
        in       = cv[i].din;
        ratio    = cv[i].rat;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    chk("conv drained", 32'(out_valid), 32'd0);

    // ratio=4, one sample per 3 clocks: keep 0,4,8 with 2-cycle latency.
    do_reset(16'd4);
    for (int k = 0; k < 12; k++) begin
      in_valid = 1'b1;
      in       = 32'(k) << 16;
      tick();
      in_valid = 1'b0;
      chk($sformatf("r4 k%0d early", k), 32'(out_valid), 32'd0);
      tick();
      chk($sformatf("r4 k%0d valid", k), 32'(out_valid), 32'((k % 4) == 0));
      if ((k % 4) == 0) chk($sformatf("r4 k%0d data", k), 32'(out_data), 32'(k));
      tick();
    end

    // Backpressure: A,B buffered, C dropped; drop during clear keeps flag.
    out_ready = 1'b0;
    do_reset(16'd1);
    in_valid = 1'b1; in = 32'h0A0A_0000; tick();
    in = 32'h0B0B_0000; tick();
    in = 32'h0C0C_0000; tick();
    in_valid = 1'b0;
    chk("bp full no ovf yet", 32'(overflow), 32'd0);
    tick();
    chk("bp valid", 32'(out_valid), 32'd1);
    chk("bp hold A", 32'(out_data), 32'h0A0A);
    chk("bp overflow", 32'(overflow), 32'd1);
    in_valid = 1'b1; in = 32'h0D0D_0000; tick();
    in_valid = 1'b0; clear_overflow = 1'b1; tick();
    clear_overflow = 1'b0;
    chk("bp set+clear", 32'(overflow), 32'd1);
    chk("bp still A", 32'(out_data), 32'h0A0A);
    out_ready = 1'b1;
    tick();
    chk("bp B valid", 32'(out_valid), 32'd1);
    chk("bp B data", 32'(out_data), 32'h0B0B);
    tick();
    chk("bp empty", 32'(out_valid), 32'd0);
    chk("bp ovf sticky", 32'(overflow), 32'd1);
    clear_overflow = 1'b1; tick();
    clear_overflow = 1'b0;
    chk("bp cleared", 32'(overflow), 32'd0);

    // Full buffer with pop and push together: nothing lost.
    out_ready = 1'b0;
    do_reset(16'd1);
    in_valid = 1'b1; in = 32'h0001_0000; tick();
    in = 32'h0002_0000; tick();
    in = 32'h0003_0000; tick();
    in_valid = 1'b0; out_ready = 1'b1;
    chk("fp head A", 32'(out_data), 32'h0001);
    tick();
    chk("fp B", 32'(out_data), 32'h0002);
    chk("fp no ovf", 32'(overflow), 32'd0);
    tick();
    chk("fp C valid", 32'(out_valid), 32'd1);
    chk("fp C", 32'(out_data), 32'h0003);
    tick();
    chk("fp empty", 32'(out_valid), 32'd0);
    chk("fp no ovf end", 32'(overflow), 32'd0);

    // ratio 8 -> 2 changed mid-period: kept samples 0,8,10,12,14.
    do_reset(16'd8);
    for (int i = 0; i < 18; i++) begin
      if (i >= 2) begin
        automatic int s = i - 2;
        automatic bit sel = (s == 0) || (s >= 8 && (s % 2) == 0);
        chk($sformatf("rc s%0d valid", s), 32'(out_valid), 32'(sel));
        if (sel) chk($sformatf("rc s%0d data", s), 32'(out_data), 32'(s));
      end
      if (i < 16) begin
        in_valid = 1'b1;
        in       = 32'(i) << 16;
        if (i >= 3) ratio = 16'd2;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end

    // Reset with two entries buffered, overflow set and counter at 5.
    out_ready = 1'b0;
    do_reset(16'd1);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in       = 32'(i + 16'h0010) << 16;
      if (i >= 2) ratio = 16'd8;
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("mr pre valid", 32'(out_valid), 32'd1);
    chk("mr pre data", 32'(out_data), 32'h0010);
    chk("mr pre ovf", 32'(overflow), 32'd1);
    rst = 1'b1; in_valid = 1'b1; in = 32'h5555_0000; tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("mr valid", 32'(out_valid), 32'd0);
    chk("mr ovf", 32'(overflow), 32'd0);
    in_valid = 1'b1; in = 32'h0777_0000; tick();
    in_valid = 1'b0; tick();
    chk("mr first sel valid", 32'(out_valid), 32'd1);
    chk("mr first sel data", 32'(out_data), 32'h0777);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
